// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch FSM encodings,
// the default reset PC and the instruction word size used for PC stepping.
package if_fetch_stage_pkg;

  // PC loaded on reset unless the top-level parameter overrides it
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Byte distance between consecutive instructions
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // Fetch FSM state encodings
  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_REQ  = 2'd0;
  localparam fetch_state_t ST_WAIT = 2'd1;
  localparam fetch_state_t ST_HOLD = 2'd2;

  // Sequential successor of an instruction address; wraps modulo 2^32
  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + WORD_BYTES;
  endfunction

endpackage

// File: rtl/if_fetch_stage_pc_reg.sv
// Program counter for the fetch stage. Holds the current fetch address and
// supports three ways of changing it: sequential +4 advance, an immediate
// redirect load, and a deferred redirect. A redirect that cannot be applied
// yet (because the request for the old PC is still being presented to
// memory) is parked in a pending-target latch and applied later via
// pend_take.
import if_fetch_stage_pkg::*;

module fetch_pc_reg #(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        pend_set,
  input  logic        pend_take,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        pend_valid
);

  logic [31:0] pend_target;

  assign pc_plus4 = next_word(pc);

  // PC update: a fresh redirect beats an older parked target, which beats +4
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_target;
    end else if (pend_take) begin
      pc <= pend_target;
    end else if (advance) begin
      pc <= pc_plus4;
    end
  end

  // Parked redirect: set while the old request is still waiting for
  // acceptance, cleared once any redirect actually lands in the PC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid  <= 1'b0;
      pend_target <= 32'h0000_0000;
    end else if (pend_set) begin
      pend_valid  <= 1'b1;
      pend_target <= redirect_target;
    end else if (redirect || pend_take) begin
      pend_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage. Issues one instruction-memory read at a time,
// buffers the returned word together with its PC+4 for the IF/ID register,
// and holds it while the hazard unit stalls. Branch/jump redirects from ID
// move the PC; any read already in flight for the wrong path is marked
// with 'kill' and its response is discarded when it arrives.
import if_fetch_stage_pkg::*;

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_Write,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_plus4_out,
  output logic        fetch_valid
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic         kill;
  logic         kill_next;

  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic         pend_valid;

  logic         accept;
  logic         advance;
  logic         redirect;
  logic         pend_set;
  logic         pend_take;
  logic         capture;
  logic         release_hold;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk             (clk),
    .reset           (reset),
    .advance         (advance),
    .redirect        (redirect),
    .redirect_target (Branch_Target),
    .pend_set        (pend_set),
    .pend_take       (pend_take),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .pend_valid      (pend_valid)
  );

  // The request is a pure decode of state and PC, so address stays stable
  // for as long as the memory keeps the request waiting
  assign imem_req  = (state == ST_REQ);
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready;

  // Next-state and PC control; redirects always win over PC_Write, and
  // PC_Write only matters once an instruction is being held
  always_comb begin
    state_next   = state;
    kill_next    = kill;
    advance      = 1'b0;
    redirect     = 1'b0;
    pend_set     = 1'b0;
    pend_take    = 1'b0;
    capture      = 1'b0;
    release_hold = 1'b0;
    case (state)
      ST_REQ: begin
        if (accept) begin
          state_next = ST_WAIT;
          if (Branch_Taken) begin
            redirect  = 1'b1;
            kill_next = 1'b1;
          end else if (pend_valid) begin
            pend_take = 1'b1;
            kill_next = 1'b1;
          end
        end else if (Branch_Taken) begin
          pend_set = 1'b1;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          state_next = ST_REQ;
          kill_next  = 1'b0;
          if (Branch_Taken) begin
            redirect = 1'b1;
          end else if (!kill) begin
            capture    = 1'b1;
            state_next = ST_HOLD;
          end
        end else if (Branch_Taken) begin
          redirect  = 1'b1;
          kill_next = 1'b1;
        end
      end
      ST_HOLD: begin
        if (Branch_Taken) begin
          redirect     = 1'b1;
          release_hold = 1'b1;
          state_next   = ST_REQ;
        end else if (PC_Write) begin
          advance      = 1'b1;
          release_hold = 1'b1;
          state_next   = ST_REQ;
        end
      end
      default: begin
        state_next = ST_REQ;
        kill_next  = 1'b0;
      end
    endcase
  end

  // FSM state and the wrong-path kill flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_REQ;
      kill  <= 1'b0;
    end else begin
      state <= state_next;
      kill  <= kill_next;
    end
  end

  // IF/ID-facing buffer: loaded from a correct-path response, invalidated
  // when the held instruction is consumed or redirected away
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instruction_out <= 32'h0000_0000;
      pc_plus4_out    <= 32'h0000_0000;
      fetch_valid     <= 1'b0;
    end else if (capture) begin
      instruction_out <= imem_rdata;
      pc_plus4_out    <= pc_plus4;
      fetch_valid     <= 1'b1;
    end else if (release_hold) begin
      fetch_valid     <= 1'b0;
    end
  end

endmodule
